// File: rtl/serial_fsm_pkg.sv
// Shared state encodings and helpers for the serial feeder and the detector blocks.
package serial_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      GAP    = 2'd3
   } feeder_state_t;

   localparam int GAP_W = 4;

   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/serial_bit_feeder_bit_shift_reg.sv
// Loadable shift register; holds the not-yet-presented bits of the current word,
// so the load value already has the first bit (exposed on 'first') removed.
module bit_shift_reg #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   output logic             first,
   output logic             tap
);

   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] load_next_s;
   logic [WIDTH-1:0] shift_next_s;

   // Direction-dependent taps and next values
   always_comb begin
      if (MSB_FIRST != 0) begin
         first        = load_data[WIDTH-1];
         tap          = data_r[WIDTH-1];
         load_next_s  = {load_data[WIDTH-2:0], 1'b0};
         shift_next_s = {data_r[WIDTH-2:0], 1'b0};
      end else begin
         first        = load_data[0];
         tap          = data_r[0];
         load_next_s  = {1'b0, load_data[WIDTH-1:1]};
         shift_next_s = {1'b0, data_r[WIDTH-1:1]};
      end
   end

   // Storage; load wins over shift
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= {WIDTH{1'b0}};
      end else if (load) begin
         data_r <= load_next_s;
      end else if (shift_en) begin
         data_r <= shift_next_s;
      end else begin
         data_r <= data_r;
      end
   end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: valid/ready word in, one qualified bit per clock out.
// Optional trailing even-parity bit when SERIAL_FEEDER_PARITY_EN is defined.
module serial_bit_feeder
   import serial_fsm_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             stall,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int                CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]     LAST     = CW'(WIDTH - 1);
   localparam logic [CW-1:0]     PENULT   = CW'(WIDTH - 2);
   localparam bit                HAS_GAP  = (GAP_CYCLES > 0);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   feeder_state_t    state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [GAP_W-1:0] gap_r, gap_s;
   logic             ser_out_r, ser_out_s;
   logic             ser_valid_r, ser_valid_s;
   logic             word_done_r, word_done_s;
   logic             busy_r, busy_s;
   logic             rdy_s, accept_s, load_s, shift_s;
   logic             first_s, tap_s;
`ifdef SERIAL_FEEDER_PARITY_EN
   logic             par_r;
`endif

   bit_shift_reg #(
      .WIDTH    (WIDTH),
      .MSB_FIRST(MSB_FIRST)
   ) u_sreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s),
      .load_data(in_data),
      .shift_en (shift_s),
      .first    (first_s),
      .tap      (tap_s)
   );

   // Ready: idle, or the final presented cycle of a frame when the next word may follow directly
   always_comb begin
      rdy_s = 1'b0;
      case (state_r)
         IDLE:  rdy_s = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
         SHIFT:  rdy_s = 1'b0;
         PARITY: rdy_s = !HAS_GAP && !stall;
`else
         SHIFT:  rdy_s = !HAS_GAP && (cnt_r == LAST) && !stall;
`endif
         GAP:   rdy_s = (gap_r == GAP_LAST) && !stall;
         default: rdy_s = 1'b0;
      endcase
   end

   assign in_ready = rst_n & rdy_s;
   assign accept_s = in_valid & in_ready;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = SHIFT;
            else          state_s = IDLE;
         end
         SHIFT: begin
            if (stall || (cnt_r != LAST)) begin
               state_s = SHIFT;
            end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
               state_s = PARITY;
`else
               if (accept_s)     state_s = SHIFT;
               else if (HAS_GAP) state_s = GAP;
               else              state_s = IDLE;
`endif
            end
         end
`ifdef SERIAL_FEEDER_PARITY_EN
         PARITY: begin
            if (stall)         state_s = PARITY;
            else if (accept_s) state_s = SHIFT;
            else if (HAS_GAP)  state_s = GAP;
            else               state_s = IDLE;
         end
`endif
         GAP: begin
            if (stall || (gap_r != GAP_LAST)) state_s = GAP;
            else if (accept_s)                state_s = SHIFT;
            else                              state_s = IDLE;
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM outputs: next values of the registered serial outputs and datapath controls
   always_comb begin
      load_s      = accept_s;
      shift_s     = 1'b0;
      cnt_s       = cnt_r;
      gap_s       = gap_r;
      ser_out_s   = ser_out_r;
      ser_valid_s = 1'b0;
      word_done_s = 1'b0;
      busy_s      = (state_s != IDLE);
      if (accept_s) begin
         ser_out_s   = first_s;
         ser_valid_s = 1'b1;
         cnt_s       = {CW{1'b0}};
      end else begin
         case (state_r)
            IDLE: ser_out_s = 1'b0;
            SHIFT: begin
               if (stall) begin
                  ser_valid_s = 1'b0;
               end else if (cnt_r != LAST) begin
                  shift_s     = 1'b1;
                  ser_out_s   = tap_s;
                  ser_valid_s = 1'b1;
                  cnt_s       = cnt_r + 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
                  word_done_s = 1'b0;
`else
                  word_done_s = (cnt_r == PENULT);
`endif
               end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
                  ser_out_s   = par_r;
                  ser_valid_s = 1'b1;
                  word_done_s = 1'b1;
`else
                  ser_out_s   = 1'b0;
                  gap_s       = {GAP_W{1'b0}};
`endif
               end
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            PARITY: begin
               if (stall) begin
                  ser_valid_s = 1'b0;
               end else begin
                  ser_out_s = 1'b0;
                  gap_s     = {GAP_W{1'b0}};
               end
            end
`endif
            GAP: begin
               if (stall) begin
                  ser_valid_s = 1'b0;
               end else begin
                  ser_out_s = 1'b0;
                  gap_s     = gap_r + 1'b1;
               end
            end
            default: ser_out_s = 1'b0;
         endcase
      end
   end

   // Registered outputs, bit counter and gap timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= {CW{1'b0}};
         gap_r       <= {GAP_W{1'b0}};
         ser_out_r   <= 1'b0;
         ser_valid_r <= 1'b0;
         word_done_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         cnt_r       <= cnt_s;
         gap_r       <= gap_s;
         ser_out_r   <= ser_out_s;
         ser_valid_r <= ser_valid_s;
         word_done_r <= word_done_s;
         busy_r      <= busy_s;
      end
   end

`ifdef SERIAL_FEEDER_PARITY_EN
   // Parity of the word captured at accept time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_r <= 1'b0;
      end else if (load_s) begin
         par_r <= even_parity(32'(in_data));
      end else begin
         par_r <= par_r;
      end
   end
`endif

   assign ser_out   = ser_out_r;
   assign ser_valid = ser_valid_r;
   assign word_done = word_done_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed self-checking bench: MSB-first/no-gap instance (dut0) and LSB-first/gap-2 instance (dut1).
module tb_serial_bit_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int F  = 8 + PAR;
   localparam int G1 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0_n, in_valid0, stall0, in_ready0, ser_out0, ser_valid0, busy0, word_done0;
   logic [7:0] in_data0;
   logic       rst1_n, in_valid1, stall1, in_ready1, ser_out1, ser_valid1, busy1, word_done1;
   logic [7:0] in_data1;

   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst0_n), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
      .stall(stall0), .ser_out(ser_out0), .ser_valid(ser_valid0), .busy(busy0), .word_done(word_done0));

   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(G1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .stall(stall1), .ser_out(ser_out1), .ser_valid(ser_valid1), .busy(busy1), .word_done(word_done1));

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] d;
      logic [7:0] ebits;
      logic       epar;
      int         st_after;
      int         st_len;
      int         ewin;
      int         edet;
   } vec_t;

   vec_t vt[6];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Send one word to dut0 and record the serial frame, optionally stalling after st_after bits
   task automatic xfer0(input logic [7:0] d, input int st_after, input int st_len,
                        output logic [31:0] bits, output int nb, output int last_c, output int done_c,
                        output int ndone, output int hold, output int det);
      logic [4:0] sh;
      int sc;
      bits = 32'd0; nb = 0; last_c = 0; done_c = 0; ndone = 0; hold = 0; det = 0; sh = 5'd0; sc = 0;
      @(negedge clk);
      in_data0 = d; in_valid0 = 1'b1; stall0 = 1'b0;
      #1;
      check("xfer0_ready_idle", int'(in_ready0), 1);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         in_valid0 = 1'b0;
         #1;
         if (ser_valid0) begin
            bits = {bits[30:0], ser_out0};
            nb++;
            last_c = c;
            sh = {sh[3:0], ser_out0};
            if (nb >= 5 && sh == 5'b11011) det++;
         end else if (nb > 0 && nb < F && ser_out0 === bits[0]) begin
            hold++;
         end else begin
            hold = hold;
         end
         if (word_done0) begin
            ndone++;
            done_c = c;
         end
         if (st_len > 0 && nb == st_after && sc < st_len) begin
            stall0 = 1'b1;
            sc++;
         end else begin
            stall0 = 1'b0;
         end
         if (nb == F) break;
      end
      stall0 = 1'b0;
   endtask

   // Send one word to dut1; record frame and the first cycle in_ready returns
   task automatic xfer1(input logic [7:0] d, output logic [31:0] bits, output int nb, output int rdy);
      bits = 32'd0; nb = 0; rdy = 0;
      @(negedge clk);
      in_data1 = d; in_valid1 = 1'b1;
      #1;
      check("xfer1_ready_idle", int'(in_ready1), 1);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         in_valid1 = 1'b0;
         #1;
         if (ser_valid1) begin
            bits = {bits[30:0], ser_out1};
            nb++;
         end
         if (in_ready1 && rdy == 0) rdy = c;
         if (rdy != 0) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] bits, mask, expb;
      int nb, last_c, done_c, ndone, hold, det, rdy, acc, first_c, nvalid;

      //            d      ebits  par  st_after st_len ewin det
      vt[0] = '{8'hD8, 8'hD8, 1'b0, 0, 0,  8, 1};
      vt[1] = '{8'hA5, 8'hA5, 1'b0, 4, 3, 11, 0};
      vt[2] = '{8'h1B, 8'h1B, 1'b0, 0, 0,  8, 1};
      vt[3] = '{8'hFF, 8'hFF, 1'b0, 0, 0,  8, 0};
      vt[4] = '{8'h07, 8'h07, 1'b1, 0, 0,  8, 0};
      vt[5] = '{8'h3C, 8'h3C, 1'b0, 2, 1,  9, 0};

      rst0_n = 1'b0; rst1_n = 1'b0;
      in_data0 = 8'h00; in_valid0 = 1'b0; stall0 = 1'b0;
      in_data1 = 8'h00; in_valid1 = 1'b0; stall1 = 1'b0;
      in_valid0 = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outs0", int'({ser_out0, ser_valid0, busy0, word_done0, in_ready0}), 0);
      check("reset_outs1", int'({ser_out1, ser_valid1, busy1, word_done1, in_ready1}), 0);
      in_valid0 = 1'b0;
      rst0_n = 1'b1; rst1_n = 1'b1;
      #1;
      check("post_reset_ready0", int'(in_ready0), 1);
      check("post_reset_busy0", int'(busy0), 0);

      // Table-driven single words on dut0
      for (int i = 0; i < 6; i++) begin
         xfer0(vt[i].d, vt[i].st_after, vt[i].st_len, bits, nb, last_c, done_c, ndone, hold, det);
         expb = (PAR != 0) ? {23'd0, vt[i].ebits, vt[i].epar} : {24'd0, vt[i].ebits};
         check($sformatf("v%0d_bits", i), int'(bits), int'(expb));
         check($sformatf("v%0d_nbits", i), nb, F);
         check($sformatf("v%0d_window", i), last_c, vt[i].ewin + PAR);
         check($sformatf("v%0d_done_pos", i), done_c, vt[i].ewin + PAR);
         check($sformatf("v%0d_done_cnt", i), ndone, 1);
         check($sformatf("v%0d_stall_hold", i), hold, vt[i].st_len);
         check($sformatf("v%0d_detect", i), det, vt[i].edet);
         repeat (2) @(negedge clk);
         #1;
         check($sformatf("v%0d_idle_busy", i), int'(busy0), 0);
      end

      // Back-to-back 1B then B0 with in_valid held
      bits = 32'd0; mask = 32'd0; acc = 0; first_c = 0; last_c = 0; nvalid = 0;
      for (int c = 0; c <= 2 * F; c++) begin
         @(negedge clk);
         in_valid0 = (acc < 2);
         in_data0  = (acc == 0) ? 8'h1B : 8'hB0;
         #1;
         if (c < 2 * F && in_ready0) mask = mask | (32'd1 << c);
         if (ser_valid0) begin
            bits = {bits[30:0], ser_out0};
            nvalid++;
            if (first_c == 0) first_c = c;
            last_c = c;
         end
         if (in_valid0 && in_ready0) acc++;
      end
      in_valid0 = 1'b0;
      check("b2b_bits", int'(bits), (PAR != 0) ? 32'h00006D61 : 32'h00001BB0);
      check("b2b_ready_mask", int'(mask), (PAR != 0) ? 32'h00000201 : 32'h00000101);
      check("b2b_nvalid", nvalid, 2 * F);
      check("b2b_first", first_c, 1);
      check("b2b_last", last_c, 2 * F);
      repeat (2) @(negedge clk);

      // LSB-first with gap on dut1
      xfer1(8'h01, bits, nb, rdy);
      check("lsb_bits", int'(bits), (PAR != 0) ? 32'h00000101 : 32'h00000080);
      check("lsb_nbits", nb, F);
      check("gap_ready_cycle", rdy, F + G1);

      // Asynchronous reset in the middle of 8'hFF
      @(negedge clk);
      in_data1 = 8'hFF; in_valid1 = 1'b1;
      nb = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         in_valid1 = 1'b0;
         #1;
         if (ser_valid1) nb++;
         if (nb == 5) break;
      end
      check("rst_mid_bits_seen", nb, 5);
      #2;
      rst1_n = 1'b0;
      #1;
      check("rst_mid_outs", int'({ser_out1, ser_valid1, busy1, word_done1, in_ready1}), 0);
      @(negedge clk);
      rst1_n = 1'b1;
      #1;
      check("rst_rel_ready", int'(in_ready1), 1);
      check("rst_rel_busy", int'(busy1), 0);
      xfer1(8'h03, bits, nb, rdy);
      check("rst_new_bits", int'(bits), (PAR != 0) ? 32'h00000180 : 32'h000000C0);
      check("rst_new_nbits", nb, F);
      check("rst_new_ready", rdy, F + G1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
